// File: rtl/serial_adder_n.sv
// Multi-cycle adder computing a + b + cin, BITS_PER_CYCLE bits per clock, LSB first.
// Define ADDER_SUB_EN to add the sub port (a - b via a + ~b + 1).

module serial_adder_slice #(
  parameter int N = 1
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         cin,
  output logic [N-1:0] s,
  output logic         cout
);

  logic [N:0] c;

  assign c[0] = cin;

  for (genvar i = 0; i < N; i++) begin : g_fa
    assign s[i]   = a[i] ^ b[i] ^ c[i];
    assign c[i+1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
  end

  assign cout = c[N];

endmodule

module serial_adder_n #(
  parameter int WIDTH          = 8,
  parameter int BITS_PER_CYCLE = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
`ifdef ADDER_SUB_EN
  input  logic             sub,
`endif
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam int BPC   = BITS_PER_CYCLE;
  localparam int STEPS = WIDTH / BPC;
  localparam int CW    = $clog2(STEPS) + 1;

  if ((WIDTH < 1) || (BPC < 1) || ((WIDTH % BPC) != 0)) begin : g_bad_params
    $error("serial_adder_n: BITS_PER_CYCLE must divide WIDTH");
  end

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    count_q, count_d;
  logic             carry_q, carry_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] psum_q, psum_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             cout_q, cout_d;
  logic             done_q, done_d;

  logic [BPC-1:0]   slice_sum;
  logic             slice_cout;
  logic [WIDTH-1:0] psum_next;

  serial_adder_slice #(
    .N(BPC)
  ) u_slice (
    .a   (a_q[BPC-1:0]),
    .b   (b_q[BPC-1:0]),
    .cin (carry_q),
    .s   (slice_sum),
    .cout(slice_cout)
  );

  // New slice bits enter at the MSB end so the finished word lines up after STEPS shifts.
  assign psum_next = (psum_q >> BPC) | (WIDTH'(slice_sum) << (WIDTH - BPC));

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    carry_d = carry_q;
    a_d     = a_q;
    b_d     = b_q;
    psum_d  = psum_q;
    sum_d   = sum_q;
    cout_d  = cout_q;
    done_d  = 1'b0;

    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = RUN;
          count_d = '0;
          a_d     = a;
          b_d     = b;
          carry_d = cin;
          psum_d  = '0;
`ifdef ADDER_SUB_EN
          if (sub) begin
            b_d     = ~b;
            carry_d = 1'b1;
          end
`endif
        end
      end
      RUN: begin
        a_d     = a_q >> BPC;
        b_d     = b_q >> BPC;
        carry_d = slice_cout;
        psum_d  = psum_next;
        count_d = count_q + CW'(1);
        if (count_q == CW'(STEPS - 1)) begin
          state_d = IDLE;
          sum_d   = psum_next;
          cout_d  = slice_cout;
          done_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      count_q <= '0;
      carry_q <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      psum_q  <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      carry_q <= carry_d;
      a_q     <= a_d;
      b_q     <= b_d;
      psum_q  <= psum_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
      done_q  <= done_d;
    end
  end

  assign busy = (state_q == RUN);
  assign done = done_q;
  assign sum  = sum_q;
  assign cout = cout_q;

endmodule
